// File: rtl/flag_branch_unit.sv
// Purpose: NZCV flag register with same-cycle bypass, branch resolution and a saturating taken-branch counter.
// Latency: a branch accepted in cycle t reports br_resolved/br_taken in cycle t+1; flags land at the next edge.
// Backpressure: stall freezes all state; flush kills the branch this cycle even while stalled.
module flag_branch_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             ex_valid,
   input  logic             ex_set_flags,
   input  logic             alu_negative,
   input  logic             alu_zero,
   input  logic             alu_carry_out,
   input  logic             alu_overflow,
   input  logic             br_valid,
   input  logic [1:0]       br_kind,
   input  logic [3:0]       br_cond,
   output logic [3:0]       nzcv,
   output logic             br_resolved,
   output logic             br_taken,
   output logic [CNT_W-1:0] taken_count
);

   localparam logic [1:0] KIND_B    = 2'b00;
   localparam logic [1:0] KIND_BCC  = 2'b01;
   localparam logic [1:0] KIND_CBZ  = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic       flag_src_alu;
   logic [3:0] eff_flags;
   logic       fn, fz, fc, fv;
   logic       cond_true;
   logic       take;
   logic       accept;
   logic       flag_we;

   // Select the flags a B.cond sees: a flag-setting instruction in EX this cycle wins over the register.
   always_comb begin
      flag_src_alu = ex_valid & ex_set_flags;
      eff_flags    = flag_src_alu ? {alu_negative, alu_zero, alu_carry_out, alu_overflow} : nzcv;
      {fn, fz, fc, fv} = eff_flags;
      flag_we      = ex_valid & ex_set_flags & ~stall;
      accept       = br_valid & ~stall & ~flush;
   end

   // Evaluate the ARMv8 condition code against the effective flags.
   always_comb begin
      cond_true = 1'b0;
      case (br_cond)
         4'b0000: cond_true = fz;
         4'b0001: cond_true = ~fz;
         4'b0010: cond_true = fc;
         4'b0011: cond_true = ~fc;
         4'b0100: cond_true = fn;
         4'b0101: cond_true = ~fn;
         4'b0110: cond_true = fv;
         4'b0111: cond_true = ~fv;
         4'b1000: cond_true = fc & ~fz;
         4'b1001: cond_true = ~fc | fz;
         4'b1010: cond_true = (fn == fv);
         4'b1011: cond_true = (fn != fv);
         4'b1100: cond_true = ~fz & (fn == fv);
         4'b1101: cond_true = fz | (fn != fv);
         default: cond_true = 1'b1;
      endcase
   end

   // Branch direction per kind; CBZ/CBNZ test the pass-through ALU result's zero flag directly.
   always_comb begin
      take = 1'b0;
      if (br_valid) begin
         case (br_kind)
            KIND_B:   take = 1'b1;
            KIND_BCC: take = cond_true;
            KIND_CBZ: take = alu_zero;
            default:  take = ~alu_zero;
         endcase
      end
   end

   // Architectural flag register; an older flag-setting instruction still commits when the branch is flushed.
   always_ff @(posedge clk) begin
      if (reset) begin
         nzcv <= 4'b0000;
      end else if (flag_we) begin
         nzcv <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
      end
   end

   // Resolution outputs: flush clears them even under stall, otherwise stall holds them.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_resolved <= 1'b0;
         br_taken    <= 1'b0;
      end else if (flush) begin
         br_resolved <= 1'b0;
         br_taken    <= 1'b0;
      end else if (!stall) begin
         br_resolved <= accept;
         br_taken    <= accept & take;
      end
   end

   // Saturating count of accepted taken branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_count <= '0;
      end else if (accept && take && (taken_count != CNT_MAX)) begin
         taken_count <= taken_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Purpose: directed self-checking bench for flag_branch_unit at CNT_W=16 and CNT_W=2.
// Latency: each step drives inputs after an edge and checks outputs just after the following edge.
// Backpressure: stall/flush scenarios are driven explicitly as directed steps.
module tb_flag_branch_unit;

   logic       clk = 1'b0;
   logic       reset, stall, flush, ex_valid, ex_set_flags;
   logic       alu_negative, alu_zero, alu_carry_out, alu_overflow;
   logic       br_valid;
   logic [1:0] br_kind;
   logic [3:0] br_cond;

   logic [3:0]  nzcv_a, nzcv_b;
   logic        res_a, res_b, tk_a, tk_b;
   logic [15:0] cnt_a;
   logic [1:0]  cnt_b;

   typedef struct {
      string      tag;
      logic [3:0] nzcv;
      logic       res;
      logic       tk;
      logic [15:0] cnt16;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   flag_branch_unit dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
      .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
      .nzcv(nzcv_a), .br_resolved(res_a), .br_taken(tk_a), .taken_count(cnt_a)
   );

   flag_branch_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
      .alu_negative(alu_negative), .alu_zero(alu_zero),
      .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
      .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond),
      .nzcv(nzcv_b), .br_resolved(res_b), .br_taken(tk_b), .taken_count(cnt_b)
   );

   task automatic check(input string tag, input string fld, input logic [15:0] got, input logic [15:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, got, want);
      end
   endtask

   task automatic idle();
      stall = 0; flush = 0; ex_valid = 0; ex_set_flags = 0;
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = 4'b0000;
      br_valid = 0; br_kind = 2'b00; br_cond = 4'b0000;
   endtask

   task automatic alu(input logic [3:0] f);
      {alu_negative, alu_zero, alu_carry_out, alu_overflow} = f;
   endtask

   task automatic br(input logic [1:0] kind, input logic [3:0] cond);
      br_valid = 1; br_kind = kind; br_cond = cond;
   endtask

   // Push the expectation for the inputs now driven, advance one edge, then pop and compare.
   task automatic step(input string tag, input logic [3:0] e_nzcv, input logic e_res, input logic e_tk,
                       input logic [15:0] e_c16, input logic [1:0] e_c2);
      exp_t e, o;
      e.tag = tag; e.nzcv = e_nzcv; e.res = e_res; e.tk = e_tk; e.cnt16 = e_c16; e.cnt2 = e_c2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      o = sb.pop_front();
      check(o.tag, "nzcv",   {12'd0, nzcv_a}, {12'd0, o.nzcv});
      check(o.tag, "res",    {15'd0, res_a},  {15'd0, o.res});
      check(o.tag, "taken",  {15'd0, tk_a},   {15'd0, o.tk});
      check(o.tag, "cnt16",  cnt_a,           o.cnt16);
      check(o.tag, "nzcv2",  {12'd0, nzcv_b}, {12'd0, o.nzcv});
      check(o.tag, "res2",   {15'd0, res_b},  {15'd0, o.res});
      check(o.tag, "taken2", {15'd0, tk_b},   {15'd0, o.tk});
      check(o.tag, "cnt2",   {14'd0, cnt_b},  {14'd0, o.cnt2});
      #1;
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk); #2;
      // Reset wins over stall, flush and a presented branch.
      reset = 1; stall = 1; flush = 1; br(2'b00, 4'b0000);
      step("reset_init", 4'b0000, 0, 0, 0, 0);
      reset = 0;

      ex_valid = 1; ex_set_flags = 1; alu(4'b1010);
      step("flag_write", 4'b1010, 0, 0, 0, 0);

      ex_valid = 1; ex_set_flags = 1; alu(4'b0110); br(2'b01, 4'b0000);
      step("bypass_eq", 4'b0110, 1, 1, 1, 1);

      ex_valid = 1; ex_set_flags = 1; alu(4'b1001);
      step("set_1001", 4'b1001, 0, 0, 1, 1);

      // ex_valid without set_flags: garbage ALU flags must not be bypassed.
      ex_valid = 1; ex_set_flags = 0; alu(4'b0110); br(2'b01, 4'b1010);
      step("ge_held", 4'b1001, 1, 1, 2, 2);

      br(2'b01, 4'b1011);
      step("lt_held", 4'b1001, 1, 0, 2, 2);

      ex_valid = 1; ex_set_flags = 1; alu(4'b1101);
      step("set_1101", 4'b1101, 0, 0, 2, 2);

      br(2'b01, 4'b1100);
      step("gt_held", 4'b1101, 1, 0, 2, 2);

      br(2'b01, 4'b1000);
      step("hi_held", 4'b1101, 1, 0, 2, 2);

      br(2'b01, 4'b1001);
      step("ls_held", 4'b1101, 1, 1, 3, 3);

      br(2'b01, 4'b0100);
      step("mi_sat2", 4'b1101, 1, 1, 4, 3);

      step("idle", 4'b1101, 0, 0, 4, 3);

      // CBNZ held by stall; a flag-setting instruction under stall must not write.
      stall = 1; ex_valid = 1; ex_set_flags = 1; alu(4'b0000); br(2'b11, 4'b0000);
      step("cbnz_stall1", 4'b1101, 0, 0, 4, 3);
      stall = 1; ex_valid = 1; ex_set_flags = 1; alu(4'b0000); br(2'b11, 4'b0000);
      step("cbnz_stall2", 4'b1101, 0, 0, 4, 3);
      ex_valid = 1; alu(4'b0000); br(2'b11, 4'b0000);
      step("cbnz_go", 4'b1101, 1, 1, 5, 3);

      alu(4'b1000); br(2'b10, 4'b0000);
      step("cbz_nz", 4'b1101, 1, 0, 5, 3);

      alu(4'b0100); br(2'b10, 4'b0000);
      step("cbz_z", 4'b1101, 1, 1, 6, 3);

      flush = 1; ex_valid = 1; ex_set_flags = 1; alu(4'b0100); br(2'b01, 4'b1110);
      step("flush_al", 4'b0100, 0, 0, 6, 3);

      br(2'b00, 4'b0000);
      step("b_uncond", 4'b0100, 1, 1, 7, 3);

      stall = 1; br(2'b00, 4'b0000);
      step("stall_hold", 4'b0100, 1, 1, 7, 3);

      flush = 1; stall = 1; ex_valid = 1; ex_set_flags = 1; alu(4'b1111); br(2'b00, 4'b0000);
      step("flush_stall", 4'b0100, 0, 0, 7, 3);

      reset = 1;
      step("reset_mid1", 4'b0000, 0, 0, 0, 0);
      reset = 0;

      for (int i = 1; i <= 5; i++) begin
         br(2'b00, 4'b0000);
         step($sformatf("b_seq%0d", i), 4'b0000, 1, 1, 16'(i), (i >= 3) ? 2'd3 : 2'(i));
      end

      br(2'b01, 4'b1111);
      step("al_1111", 4'b0000, 1, 1, 6, 3);

      reset = 1; ex_valid = 1; ex_set_flags = 1; alu(4'b1111); br(2'b00, 4'b0000);
      step("reset_mid2", 4'b0000, 0, 0, 0, 0);
      reset = 0;

      step("after_reset", 4'b0000, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  hold all state this cycle.
REQ-005 flush  input  1  kill the branch presented this cycle.
REQ-006 ex_valid  input  1  EX-stage instruction is valid.
REQ-007 ex_set_flags  input  1  EX instruction writes NZCV (ADDS/SUBS).
REQ-008 alu_negative, alu_zero, alu_carry_out, alu_overflow  input  1 each  ALU status flags from the current EX result.
REQ-009 br_valid  input  1  branch instruction presented this cycle.
REQ-010 br_kind  input  2  00 B (unconditional), 01 B.cond, 10 CBZ, 11 CBNZ.
REQ-011 br_cond  input  4  ARMv8 condition code for B.cond.
REQ-012 nzcv  output  4  architectural flags {N,Z,C,V}, registered.
REQ-013 br_resolved  output  1  registered; a branch was resolved last accepted cycle.
REQ-014 br_taken  output  1  registered; resolved branch is taken (qualified by br_resolved).
REQ-015 taken_count  output  CNT_W  saturating count of taken branches.

Function
REQ-016 Flag write: flag_we = ex_valid & ex_set_flags & ~stall; on flag_we, nzcv <= {alu_negative, alu_zero, alu_carry_out, alu_overflow} at the next edge; otherwise nzcv holds.
REQ-017 Bypass: B.cond evaluation SHALL use the incoming ALU flags when ex_valid & ex_set_flags, else the nzcv register (zero-bubble dependency).
REQ-018 Condition table: 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110/1111 AL 1.
REQ-019 CBZ taken iff alu_zero=1; CBNZ taken iff alu_zero=0 (ALU in PASS_B on the tested register, same cycle); B always taken.
REQ-020 CBZ/CBNZ SHALL NOT modify nzcv unless ex_set_flags is also asserted.
REQ-021 Latency: branch presented in cycle t with accept = br_valid & ~stall & ~flush yields br_resolved=1 and br_taken in cycle t+1.
REQ-022 When not accepted and ~stall, br_resolved <= 0 and br_taken <= 0 at next edge.
REQ-023 stall=1: nzcv, br_resolved, br_taken, taken_count all hold.
REQ-024 flush=1 (regardless of stall): br_resolved <= 0, br_taken <= 0; nzcv update per REQ-016 still applies (flagging instruction is older than the flushed branch).
REQ-025 taken_count increments by 1 on each accepted taken branch; saturates at 2^CNT_W-1, never wraps.
REQ-026 Inputs other than clk/reset are don't-care when their valid qualifier is low; outputs SHALL NOT depend on them.

Reset
REQ-027 reset=1 at a clock edge: nzcv=4'b0000, br_resolved=0, br_taken=0, taken_count=0; reset overrides stall, flush and any in-flight branch.
REQ-028 No output changes except at posedge clk.

Verification
REQ-029 Reset, then ex_valid=1, ex_set_flags=1, ALU flags N=1,Z=0,C=1,V=0 -> nzcv=4'b1010 next cycle.
REQ-030 SUBS 7-7 (Z=1,C=1) concurrent with B.cond EQ (0000) -> br_resolved=1, br_taken=1 next cycle (bypass), nzcv=4'b0110.
REQ-031 nzcv=4'b1001 held, B.cond GE (1010) -> taken=1; LT (1011) -> taken=0; GT with nzcv=4'b1101 -> taken=0.
REQ-032 CBNZ with alu_zero=0 and stall=1 for 2 cycles, then stall=0 -> outputs hold during stall; br_resolved=1, br_taken=1 one cycle after stall drops; nzcv unchanged.
REQ-033 B.cond AL with flush=1 and ADDS flags N=0,Z=1,C=0,V=0 -> br_resolved=0, nzcv=4'b0100.
REQ-034 CNT_W=2, five consecutive accepted unconditional B -> taken_count 1,2,3,3,3; assert reset mid-sequence -> all outputs 0 next cycle.
